// File: rtl/booth_mul_sequencer_pkg.sv
// Shared types for the Booth multiplier sequencer: FSM state encoding and
// counter sizing helper.
package booth_mul_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_CAPT,
      ST_DONE
   } state_e;

   // Counter must hold 0..n without wrapping.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/booth_mul_sequencer.sv
// Control stage for the sequential N-bit Booth multiplier: valid/ready operand
// intake, multiplier load/step sequencing, and a held valid/ready result.
module booth_mul_sequencer
   import booth_mul_sequencer_pkg::*;
#(
   parameter int N     = 8,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0]       in_a,
   input  logic [N-1:0]       in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               mul_rst,
   output logic               mul_load,
   output logic [N-1:0]       mul_a,
   output logic [N-1:0]       mul_b,
   input  logic [2*N-1:0]     mul_prod,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*N-1:0]     out_prod,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   localparam int unsigned       CNT_W    = cnt_width(N);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [N-1:0]        mul_a_q, mul_a_d;
   logic [N-1:0]        mul_b_q, mul_b_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [2*N-1:0]      out_prod_q, out_prod_d;
   logic [TAG_W-1:0]    out_tag_q, out_tag_d;
   logic                out_valid_q, out_valid_d;

   logic                in_xfer;
   logic                out_xfer;

   // Accepting in DONE while the result leaves lets a new pair in on the same edge.
   assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid_q & out_ready;

   assign mul_rst   = rst;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign out_valid = out_valid_q;
   assign out_prod  = out_prod_q;
   assign out_tag   = out_tag_q;
   assign busy      = (state_q != ST_IDLE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      tag_d       = tag_q;
      out_prod_d  = out_prod_q;
      out_tag_d   = out_tag_q;
      out_valid_d = out_valid_q;
      mul_load    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (in_xfer) begin
               mul_a_d = in_a;
               mul_b_d = in_b;
               tag_d   = in_tag;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            mul_load = 1'b1;
            cnt_d    = '0;
            state_d  = ST_RUN;
         end
         ST_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_CAPT;
            end
         end
         ST_CAPT: begin
            out_prod_d  = mul_prod;
            out_tag_d   = tag_q;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (out_xfer) begin
               out_valid_d = 1'b0;
               if (in_xfer) begin
                  mul_a_d = in_a;
                  mul_b_d = in_b;
                  tag_d   = in_tag;
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         tag_q       <= '0;
         out_prod_q  <= '0;
         out_tag_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         tag_q       <= tag_d;
         out_prod_q  <= out_prod_d;
         out_tag_q   <= out_tag_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Self-checking bench for booth_mul_sequencer: behavioural multiplier beside the
// DUT, transaction scoreboard checked every cycle, plus directed literal cases.
module tb_booth_mul_sequencer;

   localparam int N     = 8;
   localparam int TAG_W = 4;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [N-1:0]       in_a;
   logic [N-1:0]       in_b;
   logic [TAG_W-1:0]   in_tag;
   logic               mul_rst;
   logic               mul_load;
   logic [N-1:0]       mul_a;
   logic [N-1:0]       mul_b;
   logic [2*N-1:0]     mul_prod;
   logic               out_valid;
   logic               out_ready;
   logic [2*N-1:0]     out_prod;
   logic [TAG_W-1:0]   out_tag;
   logic               busy;

   booth_mul_sequencer #(.N(N), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .mul_rst   (mul_rst),
      .mul_load  (mul_load),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_prod  (mul_prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   function automatic logic [2*N-1:0] smul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic signed [2*N-1:0] sa;
      logic signed [2*N-1:0] sb;
      sa = {{N{a[N-1]}}, a};
      sb = {{N{b[N-1]}}, b};
      return sa * sb;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Multiplier stand-in: the product is wrong until N step edges after the load.
   logic [N-1:0] mm_a, mm_b;
   int           mm_steps;
   always @(posedge clk) begin
      if (mul_rst) begin
         mm_steps <= N;
         mul_prod <= '0;
      end else if (mul_load) begin
         mm_a     <= mul_a;
         mm_b     <= mul_b;
         mm_steps <= 0;
         mul_prod <= ~smul(mul_a, mul_b);
      end else if (mm_steps < N) begin
         mm_steps <= mm_steps + 1;
         mul_prod <= (mm_steps == N - 1) ? smul(mm_a, mm_b) : ~smul(mm_a, mm_b);
      end
   end

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [N-1:0]     a;
      logic [N-1:0]     b;
      int               acc;
   } txn_t;

   txn_t q[$];
   int   cyc = 0;
   int   last_acc = -100;
   int   n_acc = 0;
   int   n_res = 0;
   bit   mon_en = 1'b0;
   bit   have;
   bit   exp_valid;

   // Accept seen at cycle k: LOAD at k+1, operands held k+1..k+10, result from k+11.
   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         have      = (q.size() > 0);
         exp_valid = have && (cyc >= q[0].acc + 11);
         chk("mul_rst", mul_rst, rst);
         chk("busy", busy, have);
         chk("out_valid", out_valid, exp_valid);
         chk("in_ready", in_ready, !have || (exp_valid && out_ready));
         chk("mul_load", mul_load, cyc == last_acc + 1);
         if (have && cyc >= q[$].acc + 1 && cyc <= q[$].acc + 10) begin
            chk("mul_a", mul_a, q[$].a);
            chk("mul_b", mul_b, q[$].b);
         end
         if (exp_valid) begin
            chk("out_prod", out_prod, smul(q[0].a, q[0].b));
            chk("out_tag", out_tag, q[0].tag);
            if (out_ready) begin
               void'(q.pop_front());
               n_res++;
            end
         end
         if (in_valid && in_ready) begin
            q.push_back('{tag: in_tag, a: in_a, b: in_b, acc: cyc});
            last_acc = cyc;
            n_acc++;
         end
         if (rst) begin
            n_acc    = n_acc - q.size();
            q.delete();
            last_acc = -100;
         end
      end
   end

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [TAG_W-1:0] t, input bit rnd_rdy);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_tag   = t;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
            break;
         end
         @(posedge clk); #1;
         if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic wait_valid(output int n);
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (out_valid) break;
      end
   endtask

   task automatic run_one(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [TAG_W-1:0] t, input logic [2*N-1:0] exp_prod);
      int n;
      out_ready = 1'b1;
      send(a, b, t, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(n);
      chk("latency_edges", n - 1, 10);
      chk("lit_prod", out_prod, exp_prod);
      chk("lit_tag", out_tag, t);
      @(negedge clk);
      chk("idle_after", busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      int n;
      int acc0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_mul_load", mul_load, 1'b0);
      chk("rst_mul_a", mul_a, '0);
      chk("rst_mul_b", mul_b, '0);
      chk("rst_out_prod", out_prod, '0);
      chk("rst_out_tag", out_tag, '0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      run_one(8'h07, 8'hFD, 4'd5, 16'hFFEB);
      run_one(8'h80, 8'h80, 4'd1, 16'h4000);
      run_one(8'h80, 8'h7F, 4'd2, 16'hC080);
      run_one(8'h00, 8'hFF, 4'd3, 16'h0000);

      // Held result under back-pressure, then a same-edge handover.
      out_ready = 1'b0;
      send(8'h80, 8'h80, 4'd9, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(n);
      chk("hold_latency", n - 1, 10);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a     = 8'h80;
      in_b     = 8'h7F;
      in_tag   = 4'd10;
      repeat (20) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_prod", out_prod, 16'h4000);
         chk("hold_tag", out_tag, 4'd9);
         chk("hold_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", in_ready, 1'b1);
      chk("b2b_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(n);
      chk("b2b_period", n, 11);
      chk("b2b_prod", out_prod, 16'hC080);
      chk("b2b_tag", out_tag, 4'd10);
      @(negedge clk);
      chk("b2b_idle", busy, 1'b0);

      // Reset with the step counter at 4.
      send(8'h33, 8'h02, 4'd12, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("pre_rst_busy", busy, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_mul_a", mul_a, '0);
      chk("midrst_mul_b", mul_b, '0);
      chk("midrst_out_prod", out_prod, '0);
      chk("midrst_out_tag", out_tag, '0);
      chk("midrst_in_ready", in_ready, 1'b1);
      run_one(8'h05, 8'hFA, 4'd7, 16'hFFE2);

      // Continuous in_valid with random operands and random consumer stalls.
      acc0 = n_acc;
      for (int i = 0; i < 40; i++) begin
         send(8'($urandom), 8'($urandom), 4'(i), 1'b1);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !busy) break;
      end
      chk("random_accepts", n_acc - acc0, 40);
      chk("drain_busy", busy, 1'b0);
      chk("results_vs_accepts", n_res, n_acc);
      chk("scoreboard_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
